gray_window_linebuffer: RTL

GRAY_WINDOW_LINEBUFFER -- requirements
Module: gray_window_linebuffer

---
 rtl/gray_window_linebuffer_if.sv | 28 ++
 rtl/gray_window_linebuffer.sv | 117 +++++++++++
 2 files changed

// File: rtl/gray_window_linebuffer_if.sv
// Pixel-in / window-column-out handshake bundle for gray_window_linebuffer.
// slave is the line buffer side, master is the pixel source and column sink.
interface gray_window_linebuffer_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_sof;
  logic                out_valid;
  logic                out_ready;
  logic [K*DATA_W-1:0] out_col;
  logic [ADDR_W-1:0]   out_x;
  logic [15:0]         out_y;
  logic                out_eof;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_col, out_x, out_y, out_eof
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_col, out_x, out_y, out_eof
  );
endinterface

// File: rtl/gray_window_linebuffer.sv
// K-row line buffer: emits a registered vertical column of K pixels per
// accepted pixel once the frame has K-1 complete rows behind it.
module gray_window_linebuffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  gray_window_linebuffer_if.slave pix
);
  localparam int BANK_W = (K > 1) ? $clog2(K) : 1;

  logic [DATA_W-1:0]   mem [K][IMG_W];

  logic [ADDR_W-1:0]   col_cnt;
  logic [15:0]         row_cnt;
  logic [BANK_W-1:0]   bank_ptr;

  logic                out_valid_q;
  logic [K*DATA_W-1:0] out_col_q;
  logic [ADDR_W-1:0]   out_x_q;
  logic [15:0]         out_y_q;
  logic                out_eof_q;

  logic                accept;
  logic                emit;
  logic [ADDR_W-1:0]   cur_x;
  logic [15:0]         cur_y;
  logic [BANK_W-1:0]   cur_bank;
  logic                last_col;
  logic                last_row;
  logic [K*DATA_W-1:0] col_next;

  function automatic logic [BANK_W-1:0] bank_back(input logic [BANK_W-1:0] b, input int k);
    int t;
    t = int'(b) - k;
    if (t < 0) t = t + K;
    return BANK_W'(t);
  endfunction

  assign pix.in_ready  = !out_valid_q || pix.out_ready;
  assign pix.out_valid = out_valid_q;
  assign pix.out_col   = out_col_q;
  assign pix.out_x     = out_x_q;
  assign pix.out_y     = out_y_q;
  assign pix.out_eof   = out_eof_q;

  assign accept = pix.in_valid && pix.in_ready;

  // A start-of-frame pixel overrides whatever position the counters hold.
  assign cur_x    = pix.in_sof ? '0 : col_cnt;
  assign cur_y    = pix.in_sof ? '0 : row_cnt;
  assign cur_bank = pix.in_sof ? '0 : bank_ptr;

  assign last_col = (cur_x == ADDR_W'(IMG_W - 1));
  assign last_row = (cur_y == 16'(IMG_H - 1));
  assign emit     = accept && (cur_y >= 16'(K - 1));

  always_comb begin
    col_next = '0;
    col_next[0 +: DATA_W] = pix.in_data;
    for (int k = 1; k < K; k++) begin
      col_next[k*DATA_W +: DATA_W] = mem[bank_back(cur_bank, k)][cur_x];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem[cur_bank][cur_x] <= pix.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt  <= '0;
      row_cnt  <= '0;
      bank_ptr <= '0;
    end else if (accept) begin
      if (last_col) begin
        col_cnt <= '0;
        if (last_row) begin
          row_cnt  <= '0;
          bank_ptr <= '0;
        end else begin
          row_cnt  <= cur_y + 16'd1;
          bank_ptr <= (cur_bank == BANK_W'(K - 1)) ? '0 : cur_bank + 1'b1;
        end
      end else begin
        col_cnt  <= cur_x + 1'b1;
        row_cnt  <= cur_y;
        bank_ptr <= cur_bank;
      end
    end
  end

  // Single output stage: data only changes on load, so a stalled column holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_eof_q   <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_col_q   <= col_next;
      out_x_q     <= cur_x;
      out_y_q     <= cur_y;
      out_eof_q   <= last_col && last_row;
    end else if (pix.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule
